// File: rtl/imm_instr_encoder.sv
// Streaming RV32I encoder: packs register fields and a signed immediate into an
// instruction word, expanding the LI pseudo-op into LUI + ADDI.
module imm_instr_encoder #(
  parameter int CHECK_RANGE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        li_i,
  input  logic [6:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] imm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] instr_o,
  output logic        last_o,
  output logic        err_o
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_HOLD_HI} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_valid;
  logic [31:0]        r_instr;
  logic               r_last;
  logic               r_err;
  logic [31:0]        r_addi;

  logic               w_accept;
  logic               w_take;
  logic signed [31:0] w_imm;
  logic [11:0]        w_lo;
  logic [19:0]        w_hi;
  logic [31:0]        w_word1;
  logic [31:0]        w_word2;
  logic               w_last1;
  logic               w_err1;
  logic               w_two;

  // True when v is representable as a two's-complement value of the given width.
  function automatic logic fits_signed(input logic signed [31:0] v, input int unsigned bits);
    logic signed [31:0] t;
    t = v >>> (bits - 1);
    return (t == 32'sd0) || (t == -32'sd1);
  endfunction

  assign w_imm    = imm_i;
  assign w_lo     = imm_i[11:0];
  assign w_hi     = imm_i[31:12] + {19'd0, imm_i[11]};
  assign w_take   = r_valid & out_ready_i;
  assign in_ready_o = !reset & (!r_valid | (out_ready_i & r_last));
  assign w_accept = in_valid_i & in_ready_o;

  always_comb begin
    w_word1 = 32'h0000_0013;
    w_word2 = 32'h0000_0013;
    w_last1 = 1'b1;
    w_err1  = 1'b0;
    w_two   = 1'b0;
    if (li_i) begin
      // ADDI sign-extends lo, so hi carries imm[11] to compensate.
      if (w_lo == 12'd0) begin
        w_word1 = {w_hi, rd_i, 7'h37};
      end else if (w_hi == 20'd0) begin
        w_word1 = {w_lo, 5'd0, 3'b000, rd_i, 7'h13};
      end else begin
        w_word1 = {w_hi, rd_i, 7'h37};
        w_word2 = {w_lo, rd_i, 3'b000, rd_i, 7'h13};
        w_last1 = 1'b0;
        w_two   = 1'b1;
      end
    end else begin
      case (op_i)
        7'h17, 7'h37: begin
          w_word1 = {imm_i[31:12], rd_i, op_i};
          w_err1  = (imm_i[11:0] != 12'd0);
        end
        7'h13, 7'h03, 7'h67: begin
          w_word1 = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
          w_err1  = !fits_signed(w_imm, 12);
        end
        7'h23: begin
          w_word1 = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
          w_err1  = !fits_signed(w_imm, 12);
        end
        7'h63: begin
          w_word1 = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:1], imm_i[11], op_i};
          w_err1  = !fits_signed(w_imm, 13) | imm_i[0];
        end
        7'h6F: begin
          w_word1 = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
          w_err1  = !fits_signed(w_imm, 21) | imm_i[0];
        end
        default: w_err1 = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = w_two ? S_HOLD_HI : S_HOLD;
    end else if (w_take) begin
      w_state_nxt = (r_state == S_HOLD_HI) ? S_HOLD : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= 32'd0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_instr <= w_word1;
      r_last  <= w_last1;
      r_err   <= w_err1;
    end else if (w_take) begin
      r_valid <= (r_state == S_HOLD_HI);
      r_instr <= (r_state == S_HOLD_HI) ? r_addi : r_instr;
      r_last  <= 1'b1;
      r_err   <= 1'b0;
    end
  end

  // The queued ADDI half is plain data; it is only ever read from HOLD_HI.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addi <= w_word2;
    end
  end

  assign out_valid_o = r_valid;
  assign instr_o     = r_instr;
  assign last_o      = r_last;
  assign err_o       = (CHECK_RANGE != 0) ? r_err : 1'b0;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Directed bench for imm_instr_encoder: format packing, range flags, LI expansion,
// back-pressure, streaming and reset between LI halves.
module tb_imm_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_i;
  logic        li_i;
  logic [6:0]  op_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [2:0]  funct3_i;
  logic [31:0] imm_i;
  logic        out_ready_i;
  logic        in_ready_o, out_valid_o, last_o, err_o;
  logic [31:0] instr_o;
  logic        nc_in_ready, nc_out_valid, nc_last, nc_err;
  logic [31:0] nc_instr;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int c0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imm_instr_encoder #(.CHECK_RANGE(1)) dut (
    .clk(clk), .reset(reset), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .li_i(li_i), .op_i(op_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .imm_i(imm_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .instr_o(instr_o), .last_o(last_o), .err_o(err_o)
  );

  imm_instr_encoder #(.CHECK_RANGE(0)) dut_nc (
    .clk(clk), .reset(reset), .in_valid_i(in_valid_i), .in_ready_o(nc_in_ready),
    .li_i(li_i), .op_i(op_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .funct3_i(funct3_i), .imm_i(imm_i), .out_valid_o(nc_out_valid),
    .out_ready_i(out_ready_i), .instr_o(nc_instr), .last_o(nc_last), .err_o(nc_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] w, input logic l, input logic e);
    chk({tag, ".valid"}, {31'd0, out_valid_o}, 32'd1);
    chk({tag, ".instr"}, instr_o, w);
    chk({tag, ".last"},  {31'd0, last_o}, {31'd0, l});
    chk({tag, ".err"},   {31'd0, err_o},  {31'd0, e});
  endtask

  // Present one request and hold it until the edge that accepts it; returns 1ns after.
  task automatic send(input logic li, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [2:0] f3, input logic [31:0] imm);
    int n;
    li_i = li; op_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2; funct3_i = f3; imm_i = imm;
    in_valid_i = 1'b1;
    n = 0;
    while (!in_ready_o && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) begin
      n_cmp++; n_fail++;
      $error("FAIL send_timeout: observed in_ready_o=0 for 20 cycles expected 1");
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    li_i = 1'b0; op_i = 7'h0; rd_i = 5'd0; rs1_i = 5'd0; rs2_i = 5'd0;
    funct3_i = 3'd0; imm_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst.instr", instr_o, 32'd0);
    chk("rst.last",  {31'd0, last_o}, 32'd0);
    chk("rst.err",   {31'd0, err_o}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready_o}, 32'd0);
    reset = 1'b0; out_ready_i = 1'b1;
    #1;
    chk("rel.in_ready", {31'd0, in_ready_o}, 32'd1);

    // Single-word formats, streamed back to back
    send(1'b0, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFF_FFFF);
    chk_word("i_neg1", 32'hFFF3_0293, 1'b1, 1'b0);
    send(1'b0, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 32'hFFFF_FFFC);
    chk_word("b_m4", 32'hFE20_9EE3, 1'b1, 1'b0);
    send(1'b0, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 32'd3);
    chk_word("b_odd", 32'h0020_9163, 1'b1, 1'b1);
    send(1'b0, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'd2048);
    chk_word("i_2048", 32'h8003_0293, 1'b1, 1'b1);
    chk("i_2048.nc_err", {31'd0, nc_err}, 32'd0);
    chk("i_2048.nc_instr", nc_instr, 32'h8003_0293);
    send(1'b0, 7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 32'd0);
    chk_word("unsup", 32'h0000_0013, 1'b1, 1'b1);
    chk("unsup.nc_err", {31'd0, nc_err}, 32'd0);
    send(1'b0, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 32'hFFFF_FFF8);
    chk_word("s_m8", 32'hFE31_2C23, 1'b1, 1'b0);
    send(1'b0, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    chk_word("j_2048", 32'h0010_00EF, 1'b1, 1'b0);
    send(1'b0, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    chk_word("j_odd", 32'h0000_00EF, 1'b1, 1'b1);
    send(1'b0, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 32'hABCD_E000);
    chk_word("u_ok", 32'hABCD_E1B7, 1'b1, 1'b0);
    send(1'b0, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 32'd1);
    chk_word("u_low", 32'h0000_01B7, 1'b1, 1'b1);

    // Two-word LI
    send(1'b1, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 32'h1234_5FFF);
    chk_word("li.lui", 32'h1234_6537, 1'b0, 1'b0);
    chk("li.in_ready", {31'd0, in_ready_o}, 32'd0);
    @(posedge clk); #1;
    chk_word("li.addi", 32'hFFF5_0513, 1'b1, 1'b0);
    send(1'b1, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 32'h0000_5000);
    chk_word("li_lui_only", 32'h0000_5537, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("drain.valid", {31'd0, out_valid_o}, 32'd0);

    // LI held under back-pressure
    out_ready_i = 1'b0;
    send(1'b1, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 32'h0000_0800);
    for (int k = 0; k < 3; k++) begin
      chk_word("bp.lui", 32'h0000_1537, 1'b0, 1'b0);
      chk("bp.in_ready", {31'd0, in_ready_o}, 32'd0);
      @(posedge clk); #1;
    end
    chk_word("bp.lui_end", 32'h0000_1537, 1'b0, 1'b0);
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    chk_word("bp.addi", 32'h8005_0513, 1'b1, 1'b0);

    // Four I-format requests, one word per cycle
    c0 = cyc;
    send(1'b0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    chk_word("st1", 32'h0010_0093, 1'b1, 1'b0);
    send(1'b0, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2);
    chk_word("st2", 32'h0020_0113, 1'b1, 1'b0);
    send(1'b0, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd3);
    chk_word("st3", 32'h0030_0193, 1'b1, 1'b0);
    send(1'b0, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 32'd4);
    chk_word("st4", 32'h0040_0213, 1'b1, 1'b0);
    chk("st.cycles", cyc - c0, 32'd4);
    @(posedge clk); #1;
    chk("st.drain", {31'd0, out_valid_o}, 32'd0);

    // Reset at the edge that takes the LUI half
    send(1'b1, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 32'h1234_5FFF);
    chk_word("rli.lui", 32'h1234_6537, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rli.valid", {31'd0, out_valid_o}, 32'd0);
    chk("rli.instr", instr_o, 32'd0);
    chk("rli.last",  {31'd0, last_o}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rli.in_ready", {31'd0, in_ready_o}, 32'd1);
    @(posedge clk); #1;
    chk("rli.no_addi", {31'd0, out_valid_o}, 32'd0);
    chk("rli.no_addi_instr", instr_o, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_instr_encoder.md
# imm_instr_encoder

Streaming RV32I instruction encoder: accepts an opcode, register fields, funct3 and a 32-bit signed immediate, and produces the 32-bit instruction word with the immediate scattered into its format-specific bit positions. It is the inverse of `Immediate_Unit`, which extracts immediates from instruction words. It also expands the load-immediate pseudo-op (LI) into LUI+ADDI. It sits between the test/boot program generator and the instruction memory write port, with valid/ready handshakes on both sides.

## Interface
- `CHECK_RANGE`, default 1: 1 = flag immediates that do not fit the selected format; 0 = truncate silently, `err_o` tied to 0.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid_i`  in  1  request valid.
- `in_ready_o`  out  1  request accepted when `in_valid_i & in_ready_o` at a rising edge.
- `li_i`  in  1  1 = LI pseudo-op; `op_i`, `rs1_i`, `rs2_i` and `funct3_i` are ignored.
- `op_i`  in  7  opcode: 0x17, 0x37 (U); 0x13, 0x03, 0x67 (I); 0x23 (S); 0x63 (B); 0x6F (J).
- `rd_i`, `rs1_i`, `rs2_i`  in  5 each  register indices.
- `funct3_i`  in  3  funct3 field.
- `imm_i`  in  32  immediate, two's complement (U: full value, low 12 bits expected 0).
- `out_valid_o`  out  1  `instr_o` valid.
- `out_ready_i`  in  1  consumer accepts the word when `out_valid_o & out_ready_i`.
- `instr_o`  out  32  encoded instruction.
- `last_o`  out  1  final word for the current request.
- `err_o`  out  1  immediate out of range, or unsupported opcode.

## Operation
- Field packing (imm = `imm_i`):
  - U: {imm[31:12], rd, op}.
  - I: {imm[11:0], rs1, funct3, rd, op}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
- Range rules, applied when CHECK_RANGE=1:
  - I/S: -2048..2047.
  - B: -4096..4094, and the value must be even.
  - J: -1048576..1048574, and the value must be even.
  - U: imm[11:0] must be 0.
- On a range violation, the fields are still packed (truncated) and `err_o`=1.
- Unsupported `op_i`: `instr_o`=0x00000013 (NOP), `err_o`=1, `last_o`=1.
- LI expansion:
  - lo = imm[11:0]; hi = imm[31:12] + imm[11], computed mod 2^20 (wraps, no error).
  - lo==0: single word, LUI rd,hi.
  - hi==0 and lo!=0: single word, ADDI rd,x0,lo.
  - Otherwise two words: LUI rd,hi with `last_o`=0, then ADDI rd,rd,lo with `last_o`=1.
  - LI never sets `err_o`.
- FSM states:
  - IDLE: output register empty.
  - HOLD: single word or final word pending.
  - HOLD_HI: LUI pending, ADDI queued.
- FSM transitions:
  - IDLE→HOLD, or IDLE→HOLD_HI for a two-word LI, on accept.
  - HOLD_HI→HOLD when the LUI word is taken.
  - HOLD→IDLE when the word is taken with no new accept.
  - HOLD→HOLD or HOLD→HOLD_HI on a simultaneous take + accept.

## Timing
- All outputs are registered, except `in_ready_o`.
- `in_ready_o` = !reset & (!out_valid_o | (out_ready_i & last_o)).
- Latency: request accepted at edge N; word 1 is valid from edge N+1; word 2 of an LI is valid at the edge after word 1 is taken.
- Throughput: one word per cycle with no back-pressure.
  - Single-word requests stream back-to-back.
  - A two-word LI blocks intake for one extra cycle.
- While `out_valid_o` & !`out_ready_i`: `instr_o`, `last_o` and `err_o` hold stable.
- A simultaneous take of the last word and a new accept loads the new word at the same edge, with no bubble.
- Reset, effective at the next edge at any time, including between the LI halves:
  - `out_valid_o`, `last_o` and `err_o` go to 0, `instr_o` to 0x00000000, state to IDLE.
  - A pending ADDI half is discarded.
- Inputs are don't-care when `in_valid_i`=0.

## Test plan
- I-format: op 0x13, rd 5, rs1 6, funct3 0, imm 0xFFFFFFFF -> `instr_o`=0xFFF30293, `last_o`=1, `err_o`=0; decoding it with `Immediate_Unit` returns 0xFFFFFFFF.
- B-format: op 0x63, rs1 1, rs2 2, funct3 1, imm -4 -> 0xFE209EE3. Repeat with imm 3 -> `err_o`=1.
- LI: rd 10, imm 0x12345FFF -> 0x12346537 (`last_o`=0), then 0xFFF50513 (`last_o`=1).
  - imm 0x00000800 -> LUI 0x00001537 then ADDI 0x80050513.
  - imm 0x00005000 -> the single word 0x00005537.
- Range and unsupported cases, CHECK_RANGE=1:
  - op 0x13, imm 2048 -> `err_o`=1.
  - op 0x33 -> 0x00000013 with `err_o`=1.
  - With CHECK_RANGE=0, the same op 0x13 stimulus gives `err_o`=0.
- Back-pressure: hold `out_ready_i`=0 for 3 cycles with an LI pending -> LUI word stable, `in_ready_o`=0. Then stream 4 I-format requests with `out_ready_i`=1 -> one word per cycle, in order.
- Reset mid-LI: assert `reset` for one cycle right after the LUI word is taken -> next cycle `out_valid_o`=0 and `instr_o`=0; the ADDI word is never emitted; `in_ready_o`=1 after release.
